fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-stage program-counter generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. It sits directly upstream of the instruction memory: `o_pc` drives the memory's fetch address. `o_pc_ID` and `o_pred_taken_ID` are registered in lockstep with the memory's registered instruction output, so the decode stage sees PC, prediction and instruction aligned. EX-stage resolution trains the BTB and forces redirects on mispredicts.

## Interface
- `BTB_ENTRIES`, default 16: BTB depth; power of two, ≥2.
- `RESET_PC`, default 32'h0000_0000: first fetch address; bits [1:0] must be 0.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset, asynchronous, active-low.
- `stall_ID` in 1: hold PC and the ID-side registers; same signal the instruction memory receives.
- `flush_ID` in 1: zero the ID-side registers; same signal the instruction memory receives.
- `i_redirect` in 1: EX mispredict or jump correction.
- `i_redirect_pc` in 32: correct next fetch address.
- `i_upd_en` in 1: EX resolved a branch or jump this cycle.
- `i_upd_pc` in 32: PC of the resolved instruction.
- `i_upd_taken` in 1: actual outcome.
- `i_upd_target` in 32: actual taken target.
- `o_pc` out 32: fetch address to instruction memory.
- `o_pc_ID` out 32: PC of the instruction currently presented to ID.
- `o_pred_taken_ID` out 1: fetch-time prediction for that instruction.

## Operation
- **BTB indexing:** index = pc[IW+1:2], where IW = log2(BTB_ENTRIES). Tag = pc[31:IW+2].
- **BTB entry contents:** valid, tag, target[31:2], and a 2-bit counter (0–1 = predict not taken, 2–3 = predict taken). All valid bits clear on reset.
- **Lookup:** combinational on `o_pc`. Hit = valid && tag match. pred_taken = hit && counter[1]. pred_target = {target, 2'b00}.
- **Next-PC priority:**
  1. `i_redirect` → {i_redirect_pc[31:2], 2'b00}.
  2. `stall_ID` → hold.
  3. pred_taken → pred_target.
  4. Otherwise `o_pc` + 4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- **ID-side registers:** `o_pc_ID` and `o_pred_taken_ID` use the instruction memory's priority.
  - Stall: hold.
  - Else flush: load 0.
  - Else: load `o_pc` and pred_taken.
- **Update on `i_upd_en`, indexed by `i_upd_pc`:**
  - Hit: taken → counter saturating +1 (max 3) and target rewritten. Not taken → counter saturating −1 (min 0); target unchanged.
  - Miss and taken: allocate, overwriting the entry (valid=1, new tag, target, counter=2).
  - Miss and not taken: no change.
- **Simultaneous lookup and update to the same index:** lookup uses the pre-update contents. The write is visible from the next cycle.
- **Redirect during stall:** `o_pc` takes the redirect; ID-side registers hold.
- No internal stall or flush generation; the hazard unit owns both.

## Timing
- **Reset (async, any time):**
  - `o_pc`=RESET_PC, `o_pc_ID`=0, `o_pred_taken_ID`=0.
  - All BTB valid bits clear; counters=0.
  - Reset mid-operation discards in-flight state; the first edge after release resumes from RESET_PC.
- **Fetch rate:** one new `o_pc` per unstalled cycle.
- **ID-side latency:** `o_pc_ID` lags `o_pc` by exactly one edge, matching the instruction memory's registered output.
- **Redirect latency:** `i_redirect` sampled at edge n → `o_pc`=redirect PC after edge n. The instruction at that PC reaches ID after edge n+1.
- **Predicted-taken branch:** zero-bubble; target appears on `o_pc` the edge after the branch PC.
- **BTB update latency:** update sampled at edge n affects lookups in cycle n+1 onward.

## Test plan
1. **Sequential fetch.** Stimulus: reset with RESET_PC=0, release, no control inputs. Required: `o_pc` = 0, 4, 8, 0xC on successive cycles; `o_pc_ID` = 0, 0, 4, 8; `o_pred_taken_ID`=0 throughout.
2. **Stall.** Stimulus: stall_ID for 2 cycles while `o_pc`=0x8. Required: `o_pc`=0x8 and `o_pc_ID`=0x4 held for both cycles, then fetch resumes with 0xC.
3. **Redirect with flush.** Stimulus: i_redirect=1, i_redirect_pc=0x103, flush_ID=1 for one cycle. Required: next `o_pc`=0x100, `o_pc_ID`=0, `o_pred_taken_ID`=0; the cycle after, `o_pc_ID`=0x100. Also apply redirect and stall together: `o_pc` takes the redirect while `o_pc_ID` holds.
4. **BTB training.** Stimulus: update pc=0x10, taken, target=0x40, then fetch through 0x10. Required: when `o_pc`=0x10, the next `o_pc`=0x40 and `o_pred_taken_ID`=1 with `o_pc_ID`=0x10.
5. **Counter and aliasing.** Stimulus: two not-taken updates at 0x10, then fetch 0x10. Required: counter 2→1→0; fetch falls through to 0x14. Then fetch 0x50 (same index as 0x10, different tag, with BTB_ENTRIES=16). Required: miss, next `o_pc`=0x54.
6. **Wrap and reset.** Stimulus: redirect to 0xFFFF_FFFC with no stall. Required: next `o_pc`=0. Then assert `i_rst` mid-cycle. Required: outputs go to reset values immediately, and a previously trained BTB entry no longer predicts.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Fetch-stage program-counter generator with a direct-mapped branch target
// buffer (BTB) holding 2-bit saturating taken/not-taken counters.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-low reset
//   stall_ID         hold PC and the ID-side registers
//   flush_ID         zero the ID-side registers
//   i_redirect       EX correction (mispredict or jump)
//   i_redirect_pc    corrected next fetch address (low two bits ignored)
//   i_upd_en         EX resolved a branch/jump this cycle
//   i_upd_pc         PC of the resolved instruction
//   i_upd_taken      actual outcome
//   i_upd_target     actual taken target
//   o_pc             fetch address to instruction memory
//   o_pc_ID          PC of the instruction currently presented to ID
//   o_pred_taken_ID  fetch-time prediction for that instruction
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        stall_ID,
    input  logic        flush_ID,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_upd_en,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_ID,
    output logic        o_pred_taken_ID
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;

    // BTB storage. Kept in flops because every entry must clear on async reset.
    logic          valid_q [BTB_ENTRIES];
    logic [TW-1:0] tag_q   [BTB_ENTRIES];
    logic [29:0]   tgt_q   [BTB_ENTRIES];
    logic [1:0]    ctr_q   [BTB_ENTRIES];

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        pred_id_q, pred_id_d;

    // ---------------------------------------------------------------------
    // Lookup on the current fetch address (pre-update contents)
    // ---------------------------------------------------------------------
    logic [IW-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic          lk_hit;
    logic          pred_taken;
    logic [31:0]   pred_target;

    assign lk_idx      = pc_q[IW+1:2];
    assign lk_tag      = pc_q[31:IW+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = {tgt_q[lk_idx], 2'b00};

    // ---------------------------------------------------------------------
    // Next-PC and ID-side next state
    // ---------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (i_redirect) begin
            pc_d = {i_redirect_pc[31:2], 2'b00};
        end else if (stall_ID) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // Same priority as the instruction memory output register so PC,
    // prediction and instruction stay aligned at decode.
    always_comb begin
        pc_id_d   = pc_q;
        pred_id_d = pred_taken;
        if (stall_ID) begin
            pc_id_d   = pc_id_q;
            pred_id_d = pred_id_q;
        end else if (flush_ID) begin
            pc_id_d   = 32'd0;
            pred_id_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_q      <= RESET_PC;
            pc_id_q   <= 32'd0;
            pred_id_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pc_id_q   <= pc_id_d;
            pred_id_q <= pred_id_d;
        end
    end

    assign o_pc            = pc_q;
    assign o_pc_ID         = pc_id_q;
    assign o_pred_taken_ID = pred_id_q;

    // ---------------------------------------------------------------------
    // Training from EX resolution
    // ---------------------------------------------------------------------
    logic [IW-1:0] upd_idx;
    logic [TW-1:0] upd_tag;
    logic          upd_hit;
    logic [1:0]    upd_ctr;
    logic [1:0]    ctr_new;
    logic          upd_we;

    assign upd_idx = i_upd_pc[IW+1:2];
    assign upd_tag = i_upd_pc[31:IW+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr = ctr_q[upd_idx];
    // A not-taken miss leaves the BTB alone; everything else writes the entry.
    assign upd_we  = i_upd_en && (i_upd_taken || upd_hit);

    always_comb begin
        ctr_new = 2'd2;   // fresh allocation starts weakly taken
        if (upd_hit) begin
            if (i_upd_taken) begin
                ctr_new = (upd_ctr == 2'd3) ? 2'd3 : upd_ctr + 2'd1;
            end else begin
                ctr_new = (upd_ctr == 2'd0) ? 2'd0 : upd_ctr - 2'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    valid_q[gi] <= 1'b0;
                    tag_q[gi]   <= '0;
                    tgt_q[gi]   <= '0;
                    ctr_q[gi]   <= '0;
                end else if (upd_we && (upd_idx == IW'(gi))) begin
                    valid_q[gi] <= 1'b1;
                    tag_q[gi]   <= upd_tag;
                    ctr_q[gi]   <= ctr_new;
                    // Not-taken hits keep the old target.
                    if (i_upd_taken) begin
                        tgt_q[gi] <= i_upd_target[31:2];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        stall_ID = 1'b0;
    logic        flush_ID = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'd0;
    logic        i_upd_en = 1'b0;
    logic [31:0] i_upd_pc = 32'd0;
    logic        i_upd_taken = 1'b0;
    logic [31:0] i_upd_target = 32'd0;
    logic [31:0] o_pc;
    logic [31:0] o_pc_ID;
    logic        o_pred_taken_ID;

    int n_vec = 0;
    int n_err = 0;

    fetch_pc_unit #(.BTB_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .stall_ID        (stall_ID),
        .flush_ID        (flush_ID),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .i_upd_en        (i_upd_en),
        .i_upd_pc        (i_upd_pc),
        .i_upd_taken     (i_upd_taken),
        .i_upd_target    (i_upd_target),
        .o_pc            (o_pc),
        .o_pc_ID         (o_pc_ID),
        .o_pred_taken_ID (o_pred_taken_ID)
    );

    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Behavioural model: each slot remembers which word address owns it,
    // where it jumps, and a 0..3 confidence count.
    // ------------------------------------------------------------------
    bit          m_valid [16];
    logic [29:0] m_owner [16];
    logic [29:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_pc;
    logic [31:0] m_pc_id;
    logic        m_pt_id;

    function automatic int slot(input logic [31:0] pc);
        return int'(pc[31:2]) % 16;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_owner[slot(pc)] == pc[31:2]);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_pc    <= 32'd0;
            m_pc_id <= 32'd0;
            m_pt_id <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                m_valid[k] <= 1'b0;
                m_ctr[k]   <= 0;
            end
        end else begin
            if (i_redirect)       m_pc <= i_redirect_pc & 32'hFFFF_FFFC;
            else if (stall_ID)    m_pc <= m_pc;
            else if (m_pred(m_pc)) m_pc <= {m_tgt[slot(m_pc)], 2'b00};
            else                  m_pc <= m_pc + 32'd4;

            if (!stall_ID) begin
                m_pc_id <= flush_ID ? 32'd0 : m_pc;
                m_pt_id <= flush_ID ? 1'b0 : m_pred(m_pc);
            end

            if (i_upd_en) begin
                if (m_hit(i_upd_pc)) begin
                    if (i_upd_taken) begin
                        m_ctr[slot(i_upd_pc)] <= (m_ctr[slot(i_upd_pc)] >= 3) ? 3 : m_ctr[slot(i_upd_pc)] + 1;
                        m_tgt[slot(i_upd_pc)] <= i_upd_target[31:2];
                    end else begin
                        m_ctr[slot(i_upd_pc)] <= (m_ctr[slot(i_upd_pc)] <= 0) ? 0 : m_ctr[slot(i_upd_pc)] - 1;
                    end
                end else if (i_upd_taken) begin
                    m_valid[slot(i_upd_pc)] <= 1'b1;
                    m_owner[slot(i_upd_pc)] <= i_upd_pc[31:2];
                    m_tgt[slot(i_upd_pc)]   <= i_upd_target[31:2];
                    m_ctr[slot(i_upd_pc)]   <= 2;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".o_pc"}, o_pc, m_pc);
        chk({tag, ".o_pc_ID"}, o_pc_ID, m_pc_id);
        chk({tag, ".o_pred_taken_ID"}, {31'd0, o_pred_taken_ID}, {31'd0, m_pt_id});
        $display("cyc t=%0t rst=%b st=%b fl=%b rd=%b/%h up=%b/%h/%b/%h -> pc=%h id=%h pt=%b",
                 $time, i_rst, stall_ID, flush_ID, i_redirect, i_redirect_pc,
                 i_upd_en, i_upd_pc, i_upd_taken, i_upd_target, o_pc, o_pc_ID, o_pred_taken_ID);
    endtask

    task automatic lit(input string name, input logic [31:0] pc, input logic [31:0] id, input logic pt);
        chk({name, ".pc"}, o_pc, pc);
        chk({name, ".id"}, o_pc_ID, id);
        chk({name, ".pt"}, {31'd0, o_pred_taken_ID}, {31'd0, pt});
    endtask

    task automatic idle_inputs();
        stall_ID = 0; flush_ID = 0; i_redirect = 0; i_redirect_pc = 0;
        i_upd_en = 0; i_upd_pc = 0; i_upd_taken = 0; i_upd_target = 0;
    endtask

    // advance one clock edge and compare against the model at the negedge
    task automatic step(input string tag);
        @(posedge i_clk);
        @(negedge i_clk);
        cmp_model(tag);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        idle_inputs();
        i_redirect = 1; i_redirect_pc = pc;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        i_upd_en = 1; i_upd_pc = pc; i_upd_taken = taken; i_upd_target = tgt;
    endtask

    logic [31:0] pool [8] = '{32'h10, 32'h50, 32'h14, 32'h40, 32'h80, 32'h1010, 32'h3C, 32'h90};

    initial begin
        idle_inputs();
        @(negedge i_clk);
        @(negedge i_clk);
        cmp_model("reset");
        lit("reset", 32'h0, 32'h0, 1'b0);
        i_rst = 1;

        // sequential fetch
        step("seq"); lit("seq1", 32'h4, 32'h0, 1'b0);
        step("seq"); lit("seq2", 32'h8, 32'h4, 1'b0);

        // stall two cycles while o_pc = 8
        stall_ID = 1;
        step("stall"); lit("stall1", 32'h8, 32'h4, 1'b0);
        step("stall"); lit("stall2", 32'h8, 32'h4, 1'b0);
        stall_ID = 0;
        step("seq"); lit("resume", 32'hC, 32'h8, 1'b0);

        // redirect with flush, low bits dropped
        redirect_to(32'h103); flush_ID = 1;
        step("rdfl"); lit("rdfl", 32'h100, 32'h0, 1'b0);
        idle_inputs();
        step("rdfl"); lit("rdfl2", 32'h104, 32'h100, 1'b0);

        // redirect during stall: PC moves, ID holds
        redirect_to(32'h200); stall_ID = 1;
        step("rdst"); lit("rdst", 32'h200, 32'h100, 1'b0);
        idle_inputs();
        step("rdst"); lit("rdst2", 32'h204, 32'h200, 1'b0);

        // allocate 0x10 -> 0x40 and fetch through it
        redirect_to(32'h10); train(32'h10, 1, 32'h40);
        step("train"); lit("train1", 32'h10, 32'h204, 1'b0);
        idle_inputs();
        step("train"); lit("train2", 32'h40, 32'h10, 1'b1);

        // two not-taken updates: counter 2 -> 1 -> 0
        idle_inputs(); train(32'h10, 0, 32'h0);
        step("nt");
        step("nt");
        redirect_to(32'h10);
        step("nt"); lit("nt1", 32'h10, 32'h48, 1'b0);
        idle_inputs();
        step("nt"); lit("nt2", 32'h14, 32'h10, 1'b0);

        // alias: 0x50 shares the slot of 0x10 but not its tag
        redirect_to(32'h50);
        step("alias");
        idle_inputs();
        step("alias"); lit("alias", 32'h54, 32'h50, 1'b0);

        // wrap
        redirect_to(32'hFFFF_FFFC);
        step("wrap"); lit("wrap1", 32'hFFFF_FFFC, 32'h54, 1'b0);
        idle_inputs();
        step("wrap"); lit("wrap2", 32'h0, 32'hFFFF_FFFC, 1'b0);

        // train 0x80 -> 0x300, confirm it predicts, then async reset
        redirect_to(32'h80); train(32'h80, 1, 32'h300);
        step("t80");
        idle_inputs();
        step("t80"); lit("t80", 32'h300, 32'h80, 1'b1);
        #2 i_rst = 0;
        #1 lit("async_rst", 32'h0, 32'h0, 1'b0);
        @(negedge i_clk);
        cmp_model("inrst");
        i_rst = 1;
        redirect_to(32'h80);
        step("post");
        idle_inputs();
        step("post"); lit("post_rst", 32'h84, 32'h80, 1'b0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            stall_ID   = ($urandom_range(0, 99) < 20);
            flush_ID   = ($urandom_range(0, 99) < 10);
            i_redirect = ($urandom_range(0, 99) < 12);
            i_redirect_pc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            i_upd_en   = ($urandom_range(0, 99) < 35);
            i_upd_pc   = pool[$urandom_range(0, 7)];
            i_upd_taken = $urandom_range(0, 1) == 1;
            i_upd_target = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                #2 i_rst = 0;
                @(negedge i_clk);
                cmp_model("rnd_rst");
                i_rst = 1;
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
